// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) to single-port memory arbiter with fixed read latency.
// Data wins collisions unless it won the previous grant; ready pulses carry registered read data.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | m_en strobe for the latched access
// WAIT  | count down the memory read latency, capture m_rdata on the last count
// DONE  | one-cycle ready pulse to the selected port
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic [15:0]       conflicts
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            r_state;
    state_t            w_next;
    logic              r_sel;
    logic              r_last_d;
    logic              r_we;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [15:0]       r_conflicts;
    logic              w_any_req;
    logic              w_grant_d;
    logic              w_both_req;

    assign w_any_req  = if_req | d_req;
    assign w_both_req = if_req & d_req;
    assign w_grant_d  = d_req & ~(if_req & r_last_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_en     = (r_state == S_ISSUE);
        m_we     = (r_state == S_ISSUE) & r_we;
        busy     = (r_state != S_IDLE);
        if_ready = (r_state == S_DONE) & ~r_sel;
        d_ready  = (r_state == S_DONE) & r_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel       <= 1'b0;
            r_last_d    <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 4'd0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_conflicts <= 16'd0;
        end else begin
            if (r_state == S_IDLE && w_both_req && r_conflicts != 16'hFFFF) begin
                r_conflicts <= r_conflicts + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel    <= w_grant_d;
                        r_last_d <= w_grant_d;
                        r_we     <= w_grant_d & d_we;
                        r_m_addr <= w_grant_d ? d_addr : if_addr;
                        // fetches carry no write data, so the last store data is kept
                        if (w_grant_d) r_m_wdata <= d_wdata;
                    end
                end
                S_ISSUE: begin
                    if (!r_we) r_cnt <= LAT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_sel) r_d_rdata  <= m_rdata;
                        else       r_if_rdata <= m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign conflicts = r_conflicts;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter for the multicycle RISC core. It merges the core's instruction-fetch port and data load/store port onto one single-port synchronous memory with fixed read latency. The block sits between the `cpu` fetch/data outputs and the shared memory, and hands each requester a one-cycle `ready` pulse with registered read data. It replaces the split instruction/data memories with a unified 16-bit word-addressed store.

## Interface
- `ADDR_W`, 16, word address width.
- `DATA_W`, 16, data word width.
- `MEM_LAT`, 1, memory read latency in cycles from the sampling edge of `m_en` to valid `m_rdata`; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  instruction read request; held high until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req` is high.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_W  fetched word; valid with `if_ready`, held until the next fetch completes.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load; stable with `d_req`.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `d_rdata`  out  DATA_W  load data; valid with `d_ready`, held until the next load completes.
- `m_en`  out  1  memory access strobe, exactly one cycle per access.
- `m_we`  out  1  memory write strobe; high only together with `m_en`.
- `m_addr`  out  ADDR_W  registered memory address.
- `m_wdata`  out  DATA_W  registered memory write data.
- `m_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `conflicts`  out  16  saturating count of IDLE cycles in which both requests were high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE:** No request present: stay. Otherwise choose a winner, latch the winner's address, write data and `we` into `m_*` registers and a `sel` flag, then go to ISSUE.
- **Arbitration:** Data wins unless both requests are high and the previous grant went to data (`last_d` = 1). In that case the instruction port wins. `last_d` updates on every grant and resets to 0.
- **ISSUE:** `m_en` = 1, with `m_we` = latched `we`.
  - For a write, go to DONE.
  - For a read, load the wait counter with MEM_LAT and go to WAIT.
- **WAIT:** Decrement the counter each cycle. On the cycle the counter reads 1, capture `m_rdata` into `if_rdata` or `d_rdata` per `sel`, then go to DONE.
- **DONE:** Pulse `if_ready` or `d_ready` per `sel`, then return to IDLE.
- **Back-to-back requests:** A requester wanting a new access keeps `req` high after `ready`. IDLE samples it as a new request, with no bubble beyond the IDLE cycle.
- **Conflict counter:** `conflicts` increments by 1 in each IDLE cycle where both `if_req` and `d_req` are high. It saturates at 0xFFFF.
- Only the selected port's `rdata` changes. The other port's `rdata` holds its value.
- Writes never modify `if_rdata` or `d_rdata`.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_d` 0, counter 0.
- **Reset mid-operation:** reset asserted in any state aborts the transaction.
  - No `ready` pulse is produced, and no `m_en` is issued after reset.
  - A write already strobed in ISSUE is not undone.
  - After release, a still-high `req` restarts with full latency.
- **Read latency:** with `req` first high in cycle 0 and the block idle:
  - `m_en` is high in cycle 1.
  - `m_rdata` is sampled at the end of cycle 1+MEM_LAT.
  - `ready` is high in cycle MEM_LAT+2.
- **Write latency:** `m_en`/`m_we` high in cycle 1; `ready` high in cycle 2.
- **Throughput:** the next access starts at IDLE in the cycle after DONE. Back-to-back read period is MEM_LAT+3 cycles; back-to-back write period is 3 cycles.
- **Stability:** `m_addr` and `m_wdata` stay stable from ISSUE through DONE.
- **Protocol errors:** dropping `req` before `ready` does not cancel a granted access; it still completes and pulses `ready`.
- **Ready exclusivity:** `if_ready` and `d_ready` are never high in the same cycle.

## Test plan
1. **Reset values:** hold reset low, toggle inputs randomly → every output reads 0. Release reset with no requests → `busy` = 0 and `m_en` never rises.
2. **Single fetch:** MEM_LAT = 2, memory word 0x0003 = 0x1234, `if_req` high with `if_addr` = 0x0003 in cycle 0 → `m_en` high only in cycle 1, `if_ready` high only in cycle 4, `if_rdata` = 0x1234, `d_rdata` stays 0.
3. **Store then load:** store 0x00AB to `d_addr` 0x0050 → `m_we` high in cycle 1 and `d_ready` high in cycle 2. A following load from 0x0050 → `d_rdata` = 0x00AB.
4. **Collision alternation:** `if_req` and `d_req` held high continuously from reset → grants in order D, I, D, I. `conflicts` increments on each IDLE cycle with both requests high and reads 4 after four grants.
5. **Reset mid-read:** MEM_LAT = 3, reset pulsed low during WAIT → no `ready` pulse and state returns to IDLE. After release, the held `if_req` completes MEM_LAT+2 = 5 cycles later with the correct data.
6. **Counter saturation:** preload `conflicts` near its limit via a long collision run → the count stops at 0xFFFF and does not wrap.
